result_register_module: RTL and testbench

Collects result words streamed back from the GF(2^m) arithmetic units (multiply, square, invert, xor) into one result slot per operation and returns them to the sequencing state machine word by word on request. It is the return path matching the operand register bank: operands leave as 256-bit words in 1–3 beats, and results come back the same way. Each slot holds up to three 256-bit words, enough for a 768-bit field element.

---
 rtl/result_register_module.sv | 159 +++++++++++++++
 tb/tb_result_register_module.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_register_module.sv
// Result return path: collects 1-3 word results from the GF(2^m) units into one slot per op,
// and streams a completed slot back to the sequencer word by word.
module result_register_module #(
    parameter int unsigned DATA = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [9:0]      Polynomial_Length,
    input  logic            res_valid,
    input  logic [2:0]      res_op,
    input  logic [DATA-1:0] res_data,
    output logic            res_ready,
    input  logic            rd_req,
    input  logic [2:0]      rd_op,
    output logic            rd_valid,
    output logic [DATA-1:0] rd_data,
    output logic            rd_last,
    output logic [3:0]      done,
    output logic            rd_err,
    output logic            ovf
);

    localparam int unsigned SLOTS = 4;
    localparam int unsigned WORDS = 3;
    localparam logic [2:0]  MUL   = 3'd1;
    localparam logic [2:0]  SQR   = 3'd2;
    localparam logic [2:0]  INV   = 3'd3;
    localparam logic [2:0]  XOR   = 3'd4;

    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic op_valid(input logic [2:0] op);
        return (op == MUL) || (op == SQR) || (op == INV) || (op == XOR);
    endfunction

    function automatic logic [1:0] word_count(input logic [9:0] pl);
        if (!pl[9]) return 2'd1;
        if (!pl[5]) return 2'd2;
        return 2'd3;
    endfunction

    // Only bits 9 and 5 of the field degree select the word count.
    logic unused_pl;
    assign unused_pl = ^{Polynomial_Length[8:6], Polynomial_Length[4:0]};

    logic [DATA-1:0] mem   [SLOTS][WORDS];
    logic [1:0]      wr_idx[SLOTS];
    logic [1:0]      n_lat [SLOTS];

    state_t          state, state_d;
    logic [1:0]      rd_slot, rd_slot_d;
    logic [1:0]      rd_idx, rd_idx_d;
    logic            rd_valid_d, rd_last_d, rd_err_d;
    logic [DATA-1:0] rd_data_d;
    logic [3:0]      clr_done;

    logic            wr_ok, wr_fire, wr_last;
    logic [1:0]      wr_slot, n_eff;

    // The slot being streamed out is frozen against writes; all others stay open.
    assign res_ready = !rst && !(state == SEND && res_op == (3'(rd_slot) + 3'd1));

    assign wr_ok   = op_valid(res_op);
    assign wr_fire = res_valid && res_ready && wr_ok;
    assign wr_slot = 2'(res_op - 3'd1);
    // Word count is taken fresh only on the first word of a collection.
    assign n_eff   = (wr_idx[wr_slot] == 2'd0) ? word_count(Polynomial_Length) : n_lat[wr_slot];
    assign wr_last = (wr_idx[wr_slot] + 2'd1) == n_eff;

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_slot][wr_idx[wr_slot]] <= res_data;
    end

    // Per-slot collection state, done flags and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SLOTS; k++) begin
                wr_idx[k] <= 2'd0;
                n_lat[k]  <= 2'd0;
            end
            done <= 4'd0;
            ovf  <= 1'b0;
        end else begin
            for (int k = 0; k < SLOTS; k++) begin
                if (clr_done[k]) done[k] <= 1'b0;
            end
            if (res_valid && res_ready && !wr_ok) ovf <= 1'b1;
            if (wr_fire) begin
                if (done[wr_slot]) ovf <= 1'b1;
                n_lat[wr_slot] <= n_eff;
                if (wr_last) begin
                    done[wr_slot]   <= 1'b1;
                    wr_idx[wr_slot] <= 2'd0;
                end else begin
                    done[wr_slot]   <= 1'b0;
                    wr_idx[wr_slot] <= wr_idx[wr_slot] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_slot  <= 2'd0;
            rd_idx   <= 2'd0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            state    <= state_d;
            rd_slot  <= rd_slot_d;
            rd_idx   <= rd_idx_d;
            rd_valid <= rd_valid_d;
            rd_data  <= rd_data_d;
            rd_last  <= rd_last_d;
            rd_err   <= rd_err_d;
        end
    end

    // Read sequencer: done is sampled before the edge, so a same-edge completion is refused.
    always_comb begin
        state_d    = state;
        rd_slot_d  = rd_slot;
        rd_idx_d   = rd_idx;
        rd_valid_d = 1'b0;
        rd_data_d  = '0;
        rd_last_d  = 1'b0;
        rd_err_d   = 1'b0;
        clr_done   = 4'd0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    if (op_valid(rd_op) && done[2'(rd_op - 3'd1)]) begin
                        state_d   = SEND;
                        rd_slot_d = 2'(rd_op - 3'd1);
                        rd_idx_d  = 2'd0;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem[rd_slot][rd_idx];
                if (rd_idx == n_lat[rd_slot] - 2'd1) begin
                    rd_last_d         = 1'b1;
                    state_d           = IDLE;
                    clr_done[rd_slot] = 1'b1;
                end else begin
                    rd_idx_d = rd_idx + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_result_register_module.sv
// Bench for result_register_module: directed scenarios plus a random write/read mix,
// checked against a per-slot word-list model of the result bank.
module tb_result_register_module;

    logic         clk;
    logic         rst;
    logic [9:0]   Polynomial_Length;
    logic         res_valid;
    logic [2:0]   res_op;
    logic [255:0] res_data;
    logic         res_ready;
    logic         rd_req;
    logic [2:0]   rd_op;
    logic         rd_valid;
    logic [255:0] rd_data;
    logic         rd_last;
    logic [3:0]   done;
    logic         rd_err;
    logic         ovf;

    result_register_module dut (
        .clk               (clk),
        .rst               (rst),
        .Polynomial_Length (Polynomial_Length),
        .res_valid         (res_valid),
        .res_op            (res_op),
        .res_data          (res_data),
        .res_ready         (res_ready),
        .rd_req            (rd_req),
        .rd_op             (rd_op),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .rd_last           (rd_last),
        .done              (done),
        .rd_err            (rd_err),
        .ovf               (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [255:0] m_words[4][3];
    int           m_cnt[4];
    int           m_n[4];
    bit           m_done[4];
    bit           m_ovf;

    function automatic int nw(input int pl);
        if (pl < 512) return 1;
        if (((pl / 32) % 2) == 1) return 3;
        return 2;
    endfunction

    function automatic logic [3:0] m_done_vec();
        return {m_done[3], m_done[2], m_done[1], m_done[0]};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            m_cnt[s] = 0; m_n[s] = 0; m_done[s] = 0;
        end
        m_ovf = 0;
    endfunction

    function automatic void model_write(input int op, input logic [255:0] d, input int pl);
        int s;
        if (op < 1 || op > 4) begin
            m_ovf = 1;
            return;
        end
        s = op - 1;
        if (m_done[s]) begin
            m_ovf = 1; m_done[s] = 0; m_cnt[s] = 0;
        end
        if (m_cnt[s] == 0) m_n[s] = nw(pl);
        m_words[s][m_cnt[s]] = d;
        m_cnt[s]++;
        if (m_cnt[s] == m_n[s]) begin
            m_done[s] = 1; m_cnt[s] = 0;
        end
    endfunction

    // Called at a falling edge; one word presented for one cycle.
    task automatic wr_word(input int op, input logic [255:0] d);
        res_valid = 1'b1; res_op = 3'(op); res_data = d;
        #1;
        checks++;
        if (res_ready !== 1'b1) begin
            failures++; $display("FAIL wr_ready op=%0d got=%b exp=1", op, res_ready);
        end
        @(negedge clk);
        res_valid = 1'b0;
        model_write(op, d, int'(Polynomial_Length));
        checks++;
        if (done !== m_done_vec()) begin
            failures++; $display("FAIL wr_done op=%0d got=%b exp=%b", op, done, m_done_vec());
        end
        checks++;
        if (ovf !== m_ovf) begin
            failures++; $display("FAIL wr_ovf op=%0d got=%b exp=%b", op, ovf, m_ovf);
        end
    endtask

    // Full read of a complete slot; returns in the cycle showing rd_last.
    task automatic read_slot(input int op);
        int s, n;
        s = op - 1;
        n = m_n[s];
        rd_req = 1'b1; rd_op = 3'(op);
        @(negedge clk);
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
            failures++; $display("FAIL rd_lat op=%0d got valid=%b err=%b exp 0 0", op, rd_valid, rd_err);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b1 || rd_last !== (i == n - 1) || rd_data !== m_words[s][i]) begin
                failures++;
                $display("FAIL rd_beat op=%0d i=%0d got v=%b l=%b d=%h exp l=%b d=%h",
                         op, i, rd_valid, rd_last, rd_data, (i == n - 1), m_words[s][i]);
            end
        end
        m_done[s] = 0;
        checks++;
        if (done !== m_done_vec()) begin
            failures++; $display("FAIL rd_done op=%0d got=%b exp=%b", op, done, m_done_vec());
        end
    endtask

    task automatic read_refused(input int op);
        rd_req = 1'b1; rd_op = 3'(op);
        @(negedge clk);
        rd_req = 1'b0;
        checks++;
        if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL rd_err_pulse op=%0d got err=%b valid=%b exp 1 0", op, rd_err, rd_valid);
        end
        @(negedge clk);
        checks++;
        if (rd_err !== 1'b0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL rd_err_clear op=%0d got err=%b valid=%b exp 0 0", op, rd_err, rd_valid);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_valid, rd_last, rd_err, ovf, res_ready} !== 5'b0 || done !== 4'd0 || rd_data !== 256'd0) begin
            failures++;
            $display("FAIL reset_outs got v=%b l=%b e=%b o=%b r=%b done=%b exp all 0",
                     rd_valid, rd_last, rd_err, ovf, res_ready, done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_n1();
        logic [255:0] d;
        d = {32{8'hA5}};
        Polynomial_Length = 10'd163;
        wr_word(1, d);
        read_slot(1);
        @(negedge clk);
    endtask

    task automatic test_n3();
        Polynomial_Length = 10'd571;
        wr_word(2, 256'd1);
        wr_word(2, 256'd2);
        wr_word(2, 256'd3);
        read_slot(2);
        @(negedge clk);
    endtask

    task automatic test_n2_hold();
        Polynomial_Length = 10'd512;
        wr_word(3, 256'd7);
        Polynomial_Length = 10'd163;
        wr_word(3, 256'd8);
        read_slot(3);
        @(negedge clk);
    endtask

    task automatic test_send_block();
        logic [255:0] mdat;
        mdat = rnd256();
        Polynomial_Length = 10'd571;
        for (int i = 0; i < 3; i++) wr_word(4, rnd256());
        Polynomial_Length = 10'd163;
        rd_req = 1'b1; rd_op = 3'd4;
        @(negedge clk);
        rd_req = 1'b0;
        res_valid = 1'b1; res_op = 3'd4; res_data = rnd256();
        #1;
        checks++;
        if (res_ready !== 1'b0) begin
            failures++; $display("FAIL send_block0 got=%b exp=0", res_ready);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== m_words[3][0]) begin
            failures++; $display("FAIL send_w0 got v=%b d=%h exp d=%h", rd_valid, rd_data, m_words[3][0]);
        end
        res_op = 3'd1; res_data = mdat;
        #1;
        checks++;
        if (res_ready !== 1'b1) begin
            failures++; $display("FAIL send_mul_ready got=%b exp=1", res_ready);
        end
        @(negedge clk);
        model_write(1, mdat, 163);
        checks++;
        if (rd_valid !== 1'b1 || rd_last !== 1'b0 || rd_data !== m_words[3][1]) begin
            failures++; $display("FAIL send_w1 got v=%b l=%b d=%h exp d=%h", rd_valid, rd_last, rd_data, m_words[3][1]);
        end
        res_op = 3'd4;
        #1;
        checks++;
        if (res_ready !== 1'b0) begin
            failures++; $display("FAIL send_block1 got=%b exp=0", res_ready);
        end
        @(negedge clk);
        res_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_last !== 1'b1 || rd_data !== m_words[3][2]) begin
            failures++; $display("FAIL send_w2 got v=%b l=%b d=%h exp d=%h", rd_valid, rd_last, rd_data, m_words[3][2]);
        end
        m_done[3] = 0;
        @(negedge clk);
        checks++;
        if (done !== m_done_vec() || res_ready !== 1'b1) begin
            failures++; $display("FAIL send_after got done=%b ready=%b exp done=%b ready=1", done, res_ready, m_done_vec());
        end
        read_slot(1);
        @(negedge clk);
    endtask

    task automatic test_errors();
        read_refused(2);
        read_refused(5);
        read_refused(0);
    endtask

    task automatic test_invalid_op();
        apply_reset();
        wr_word(6, rnd256());
        wr_word(0, rnd256());
    endtask

    task automatic test_overwrite();
        apply_reset();
        Polynomial_Length = 10'd571;
        for (int i = 0; i < 6; i++) wr_word(1, rnd256());
        read_slot(1);
        @(negedge clk);
    endtask

    task automatic test_reset_midread();
        Polynomial_Length = 10'd571;
        for (int i = 0; i < 3; i++) wr_word(4, rnd256());
        Polynomial_Length = 10'd163;
        wr_word(3, rnd256());
        rd_req = 1'b1; rd_op = 3'd4;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== m_words[3][1]) begin
            failures++; $display("FAIL mid_beat2 got v=%b d=%h exp d=%h", rd_valid, rd_data, m_words[3][1]);
        end
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b0 || done !== 4'd0) begin
                failures++; $display("FAIL post_rst_quiet cyc=%0d got v=%b done=%b exp 0 0", i, rd_valid, done);
            end
        end
        wr_word(1, rnd256());
        read_slot(1);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        Polynomial_Length = 10'd163;
        wr_word(1, rnd256());
        wr_word(2, rnd256());
        read_slot(1);
        read_slot(2);
        read_refused(2);
    endtask

    task automatic test_random();
        int pls[7] = '{163, 233, 283, 409, 512, 571, 600};
        int op;
        apply_reset();
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) != 3) begin
                Polynomial_Length = 10'(pls[$urandom_range(0, 6)]);
                op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(1, 4));
                wr_word(op, rnd256());
            end else begin
                op = int'($urandom_range(1, 4));
                if (m_done[op - 1]) read_slot(op);
                else read_refused(op);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        Polynomial_Length = 10'd163;
        res_valid = 1'b0; res_op = 3'd0; res_data = '0;
        rd_req = 1'b0; rd_op = 3'd0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_n1();
        test_n3();
        test_n2_hold();
        test_send_block();
        test_errors();
        test_invalid_op();
        test_overwrite();
        test_reset_midread();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
